// File: rtl/bitonic_pkg.sv
// Shared types and elaboration-time helpers for the iterative bitonic sorter.
package bitonic_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of compare-exchange passes for a vector of 2**index_width words.
  function automatic int num_passes(input int index_width);
    return index_width * (index_width + 1) / 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_t;

endpackage

// File: rtl/bitonic_cx_stage.sv
// One bitonic compare-exchange stage, reused for every pass by the controller.
// The pairing distance comes from j and the block direction from k and desc.

module max_min #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] larger,
  output logic [width-1:0] smaller
);

  // Unsigned order; on equal words both outputs carry the same value.
  always_comb begin
    if (a > b) begin
      larger  = a;
      smaller = b;
    end else begin
      larger  = b;
      smaller = a;
    end
  end

endmodule

module bitonic_cx_stage
  import bitonic_pkg::*;
#(
  parameter int width       = 8,
  parameter int index       = 8,
  parameter int index_width = 3,
  parameter int kw          = clog2(index_width + 2)
) (
  input  logic [width-1:0] vec_in  [0:index-1],
  input  logic [kw-1:0]    k,
  input  logic [kw-1:0]    j,
  input  logic             desc,
  output logic [width-1:0] vec_out [0:index-1]
);

  localparam int HALF = index / 2;

  logic [width-1:0] a_word  [0:HALF-1];
  logic [width-1:0] b_word  [0:HALF-1];
  logic [width-1:0] larger  [0:HALF-1];
  logic [width-1:0] smaller [0:HALF-1];

  // Pair number m maps to the lower word index by inserting a 0 at bit j.
  function automatic logic [index_width-1:0] lo_of(input int m, input logic [kw-1:0] jj);
    int r;
    r = ((m >> jj) << (jj + 1)) | (m & ((1 << jj) - 1));
    return r[index_width-1:0];
  endfunction

  function automatic logic [index_width-1:0] hi_of(input int m, input logic [kw-1:0] jj);
    return lo_of(m, jj) | (index_width'(1) << jj);
  endfunction

  // Blocks with bit k clear sort upward; desc flips every block.
  function automatic logic dir_up(input logic [index_width-1:0] lo, input logic [kw-1:0] kk,
                                  input logic d);
    int r;
    r = int'(lo) >> kk;
    return ((r & 1) == 0) ^ d;
  endfunction

  // Gather both words of every pair for the comparators.
  always_comb begin
    for (int m = 0; m < HALF; m++) begin
      a_word[m] = vec_in[lo_of(m, j)];
      b_word[m] = vec_in[hi_of(m, j)];
    end
  end

  for (genvar m = 0; m < HALF; m++) begin : g_cx
    max_min #(.width(width)) u_mm (
      .a      (a_word[m]),
      .b      (b_word[m]),
      .larger (larger[m]),
      .smaller(smaller[m])
    );
  end

  // Scatter min/max back to the pair positions according to block direction.
  always_comb begin
    vec_out = vec_in;
    for (int m = 0; m < HALF; m++) begin
      if (dir_up(lo_of(m, j), k, desc)) begin
        vec_out[lo_of(m, j)] = smaller[m];
        vec_out[hi_of(m, j)] = larger[m];
      end else begin
        vec_out[lo_of(m, j)] = larger[m];
        vec_out[hi_of(m, j)] = smaller[m];
      end
    end
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Iterative bitonic sorter: one vector in flight, one compare-exchange pass per
// cycle through a shared stage, valid/ready on both sides.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int width       = 8,
  parameter int index       = 8,
  parameter int index_width = 3,
  localparam int NUM_PASSES = num_passes(index_width),
  localparam int PW         = (clog2(NUM_PASSES) > 0) ? clog2(NUM_PASSES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_desc,
  input  logic [width-1:0] in_data  [0:index-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data [0:index-1],
  output logic             busy,
  output logic [PW-1:0]    pass_cnt
);

  localparam int KW = clog2(index_width + 2);

  sort_state_t      state_q;
  sort_state_t      state_d;
  logic [width-1:0] work_q [0:index-1];
  logic [width-1:0] cx_out [0:index-1];
  logic             desc_q;
  logic [PW-1:0]    pass_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    j_q;
  logic             accept;
  logic             last_pass;

  assign accept    = in_valid & in_ready;
  assign last_pass = (pass_q == PW'(NUM_PASSES - 1));
  assign out_data  = work_q;
  assign pass_cnt  = pass_q;

  bitonic_cx_stage #(
    .width      (width),
    .index      (index),
    .index_width(index_width),
    .kw         (KW)
  ) u_cx (
    .vec_in (work_q),
    .k      (k_q),
    .j      (j_q),
    .desc   (desc_q),
    .vec_out(cx_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: sort for exactly NUM_PASSES cycles, reload straight from DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SORT;
      SORT:    if (last_pass) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? SORT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; in DONE the input side opens as soon as the result leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      SORT:    busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Working register and pass sequencing; touched only on accept or while sorting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '{default: '0};
      desc_q <= 1'b0;
      pass_q <= '0;
      k_q    <= KW'(1);
      j_q    <= '0;
    end else if (accept) begin
      work_q <= in_data;
      desc_q <= in_desc;
      pass_q <= '0;
      k_q    <= KW'(1);
      j_q    <= '0;
    end else if (state_q == SORT) begin
      work_q <= cx_out;
      pass_q <= pass_q + 1'b1;
      if (j_q == '0) begin
        k_q <= k_q + 1'b1;
        j_q <= k_q;
      end else begin
        j_q <= j_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Self-checking bench for bitonic_sort_ctrl: a plain-sort reference model with
// transaction timing, a per-cycle compare process and directed literal checks.
module tb_bitonic_sort_ctrl;
  import bitonic_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int NP = num_passes(IW);
  localparam int PW = clog2(NP);

  typedef logic [W-1:0] vec_t [0:N-1];

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_desc;
  vec_t          in_data;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_data;
  logic          busy;
  logic [PW-1:0] pass_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: 0 idle, 1 sorting, 2 holding a result.
  int   m_mode = 0;
  int   m_pass = 0;
  vec_t m_exp;
  int   m_accepts = 0;
  int   m_outs = 0;
  int   dut_outs = 0;
  bit   m_acc;

  bitonic_sort_ctrl #(.width(W), .index(N), .index_width(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_desc  (in_desc),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input vec_t v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
    return r;
  endfunction

  // Plain bubble sort, word 0 first.
  function automatic vec_t model_sort(input vec_t v, input logic desc);
    vec_t r;
    logic [W-1:0] t;
    r = v;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N - 1; b++)
        if (desc ? (r[b] < r[b+1]) : (r[b] > r[b+1])) begin
          t = r[b]; r[b] = r[b+1]; r[b+1] = t;
        end
    return r;
  endfunction

  function automatic bit model_in_ready();
    return (m_mode == 0) || (m_mode == 2 && out_ready === 1'b1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired waiting for DUT", name);
  endtask

  // Transaction-level model: accept, NP sorting cycles, hold until consumed.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0;
      m_pass = 0;
    end else begin
      m_acc = in_valid && model_in_ready();
      if (m_mode == 2 && out_ready) m_outs++;
      if (m_mode == 1) begin
        m_pass++;
        if (m_pass == NP) m_mode = 2;
      end else if (m_acc) begin
        m_exp = model_sort(in_data, in_desc);
        m_pass = 0;
        m_mode = 1;
        m_accepts++;
      end else if (m_mode == 2 && out_ready) begin
        m_mode = 0;
      end
    end
  end

  // Count delivered results as the DUT presents them.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) dut_outs++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("in_ready", in_ready, model_in_ready());
      checkOutput("out_valid", out_valid, m_mode == 2);
      checkOutput("busy", busy, m_mode == 1);
      if (m_mode == 1) checkOutput("pass_cnt", pass_cnt, m_pass);
      if (m_mode == 2) checkOutput("out_data", pack(out_data), pack(m_exp));
    end
  end

  // Offer a vector until the model reports it accepted; returns 1 after that edge.
  task automatic applyStimulus(input vec_t v, input logic desc, input bit rand_ready);
    int start;
    start = m_accepts;
    in_valid = 1'b1;
    in_data = v;
    in_desc = desc;
    for (int c = 0; c < 200 && m_accepts == start; c++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if (m_accepts == start) timeoutFail("accept_timeout");
    in_valid = 1'b0;
    in_data = '{default: 8'hA5};
    in_desc = 1'b0;
  endtask

  // Count edges from accept to out_valid; busy must stay high meanwhile.
  task automatic waitResult(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      checkOutput({name, "_busy"}, busy, 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) timeoutFail({name, "_result_timeout"});
    checkOutput({name, "_latency"}, cyc, NP);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t v_a, v_a_exp, v_d, v_d_exp, v_b, v_b_exp, v_r, v_r_exp, v_rand;
  logic [63:0] held;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_desc = 1'b0;
    in_data = '{default: '0};
    out_ready = 1'b0;
    v_a     = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    v_a_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    v_d     = '{8'd3, 8'd9, 8'd3, 8'd0, 8'd255, 8'd9, 8'd1, 8'd0};
    v_d_exp = '{8'd255, 8'd9, 8'd9, 8'd3, 8'd3, 8'd1, 8'd0, 8'd0};
    v_b     = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_b_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    v_r     = '{8'd5, 8'd200, 8'd17, 8'd5, 8'd0, 8'd99, 8'd42, 8'd1};
    v_r_exp = '{8'd200, 8'd99, 8'd42, 8'd17, 8'd5, 8'd5, 8'd1, 8'd0};

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_pass_cnt", pass_cnt, 0);
    checkOutput("rst_out_data", pack(out_data), 64'd0);
    rst = 1'b1;

    checkOutput("pin_model_asc", pack(model_sort(v_a, 1'b0)), pack(v_a_exp));
    checkOutput("pin_model_desc", pack(model_sort(v_d, 1'b1)), pack(v_d_exp));

    $display("[TB] ascending sort with backpressure");
    @(negedge clk);
    #1;
    applyStimulus(v_a, 1'b0, 1'b0);
    waitResult("asc");
    checkOutput("asc_data", pack(out_data), pack(v_a_exp));
    in_valid = 1'b1;
    in_data = v_d;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_data", pack(out_data), pack(v_a_exp));
    end
    in_valid = 1'b0;
    consume();
    checkOutput("bp_release_out_valid", out_valid, 1'b0);
    checkOutput("bp_release_in_ready", in_ready, 1'b1);
    checkOutput("bp_release_busy", busy, 1'b0);

    $display("[TB] descending sort with duplicates, then back-to-back");
    applyStimulus(v_d, 1'b1, 1'b0);
    waitResult("desc");
    checkOutput("desc_data", pack(out_data), pack(v_d_exp));
    out_ready = 1'b1;
    applyStimulus(v_b, 1'b0, 1'b0);
    out_ready = 1'b0;
    checkOutput("b2b_busy", busy, 1'b1);
    waitResult("b2b");
    checkOutput("b2b_data", pack(out_data), pack(v_b_exp));
    consume();

    $display("[TB] reset in the middle of a sort");
    applyStimulus(v_d, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_pass_cnt", pass_cnt, 3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    checkOutput("mid_rst_pass_cnt", pass_cnt, 0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(v_r, 1'b1, 1'b0);
    waitResult("post_rst");
    checkOutput("post_rst_data", pack(out_data), pack(v_r_exp));
    held = pack(out_data);
    consume();

    $display("[TB] random regression");
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < N; i++)
        v_rand[i] = W'($urandom_range(0, (n % 3 == 0) ? 3 : 255));
      applyStimulus(v_rand, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && m_mode != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (m_mode != 0) timeoutFail("drain_timeout");
    out_ready = 1'b0;
    checkOutput("handshake_count", dut_outs, m_outs);
    checkOutput("delivered_count", dut_outs, m_accepts - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound in case the DUT stops handshaking altogether.
  initial begin
    #3000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
- Iterative bitonic sorter: accepts one vector of `index` unsigned words, sorts it in place by reusing a single compare-exchange stage once per pass, then presents the sorted vector.
- Trades the fully pipelined sort network's area for latency: one vector in flight, NUM_PASSES cycles per sort.
- Sits between a vector producer and consumer on valid/ready handshakes.
- Pass sequencing is owned by an internal FSM and pass counter.

Parameters:
- width, 8, bits per data word (unsigned)
- index, 8, words per vector; power of two, >= 2
- index_width, 3, log2(index); derived NUM_PASSES = index_width*(index_width+1)/2 (6 at default)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_desc  in  1  sort order, sampled with the input handshake: 0 = ascending (word 0 smallest), 1 = descending
- in_data  in  width x [0:index-1]  unpacked input vector
- out_valid  out  1  sorted vector available
- out_ready  in  1  consumer accepts the vector
- out_data  out  width x [0:index-1]  sorted vector; driven directly from the working register
- busy  out  1  high in SORT state
- pass_cnt  out  ceil(log2(NUM_PASSES)) bits  current pass number, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, working register all 0, desc_q=0, pass counter=0, k=1, j=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, pass_cnt=0.
- States:
  - IDLE: in_ready=1. On in_valid: load in_data into the working register, capture desc_q=in_desc, pass=0, k=1, j=0, go to SORT.
  - SORT: each cycle, register <= cx_stage(register, k, j, desc_q) and pass++.
    - Step update: if j==0 then k++, j=k (the old k); else j--.
    - Default pass order (k,j): (1,0) (2,1) (2,0) (3,2) (3,1) (3,0).
    - On the cycle that applies pass NUM_PASSES-1, go to DONE.
    - in_ready=0 and out_valid=0 throughout SORT.
  - DONE: out_valid=1, out_data stable.
    - On out_ready && !in_valid: go to IDLE.
    - On out_ready && in_valid: load the new vector and go straight to SORT. in_ready = out_ready in DONE, so back-to-back operation loses no cycle.
    - On !out_ready: hold state and data indefinitely.
- Compare-exchange rule for pass (k,j):
  - For each i with bit j of i == 0, pair i with p = i + 2^j.
  - Direction up = (bit k of i == 0) XOR desc_q. For k == index_width, bit k is 0.
  - If up: word i gets the min of the pair and word p gets the max; otherwise reversed.
  - Comparison is unsigned. On equal words, no swap.
- Latency: a handshake in cycle t gives out_valid=1 in cycle t+1+NUM_PASSES (t+7 at default). Throughput is one vector per NUM_PASSES+1 cycles.
- in_data is ignored whenever in_ready=0.
- Reset asserted mid-SORT or in DONE: the vector is discarded, state returns to IDLE immediately, and out_valid drops asynchronously.
- Working register and pass state are updated only on an accept or in SORT. No other cycle modifies them.

Decomposition:
- Shared package bitonic_pkg:
  - function clog2
  - function num_passes(index_width)
  - enum type sort_state_t {IDLE, SORT, DONE}
- One sub-module, bitonic_cx_stage: purely combinational.
  - Inputs: vector, k, j, desc.
  - Output: exchanged vector.
  - Built from `index`/2 max_min instances with a mux on the pairing and direction.
- The FSM, pass counter and working register live in bitonic_sort_ctrl.

Test Plan:
- Ascending sort: in_data {7,6,5,4,3,2,1,0}, in_desc=0, accept at cycle 0 -> out_valid at cycle 7 with out_data {0,1,2,3,4,5,6,7}; busy high in cycles 1-6.
- Descending sort with duplicates: {3,9,3,0,255,9,1,0}, in_desc=1 -> {255,9,9,3,3,1,0,0}.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, data unchanged, in_ready=0; release -> IDLE next cycle.
- Back-to-back: in DONE, out_ready=1 and in_valid=1 with {1,0,...} -> old vector consumed, new vector loaded the same cycle, next out_valid 7 cycles later.
- Reset mid-sort: pull rst low at pass 3 -> out_valid=0, in_ready=1, pass_cnt=0 immediately; next sort after release is correct.
- Random regression: 1000 random vectors with random in_desc and random out_ready stalls -> every output matches the reference model sort.
